rejudge_ctrl: RTL and testbench
===============================

# rejudge_ctrl

Judge-side rejudge controller for the answering machine: walks the judge through selecting a player, a problem, and a score adjustment with single-cycle button pulses, then commits the new score to an internal four-entry score table. It sits directly upstream of the rejudge display tube. It drives that tube's `player`, `score` and `problemID` inputs, and exports the full score table to the rest of the design.

## Interface
- `MAX_PROB`, 20: highest problem ID; IDs run 1..MAX_PROB (≤ 99).
- `STEP`, 1: points added or removed per up/down pulse in ADJUST.
- `SCORE_MAX`, 99: score saturation ceiling (≤ 99, two BCD digits downstream).
- `INIT_SCORE`, 0: table value after reset.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; enter rejudge mode from IDLE.
- `btn_up` in 1: pulse; increment the current selection.
- `btn_down` in 1: pulse; decrement the current selection.
- `btn_ok` in 1: pulse; advance to the next stage, or commit in ADJUST.
- `btn_cancel` in 1: pulse; abort to IDLE with no table change.
- `btn_undo` in 1: pulse; revert the last commit. Ignored unless `REJUDGE_UNDO_EN` is defined.
- `player` out 2: selected player, 0..3.
- `problemID` out 8: selected problem, binary 1..MAX_PROB.
- `score` out 8: binary score shown to the tube.
- `active` out 1: high whenever state ≠ IDLE.
- `stage` out 2: state encoding. 0 IDLE, 1 SEL_PLAYER, 2 SEL_PROB, 3 ADJUST.
- `commit` out 1: one-cycle pulse when the table is written.
- `scores` out 32: {p3, p2, p1, p0}, 8 bits each.

## Operation
- Button priority within a cycle: cancel > ok > up > down.
  - up and down asserted together: no change.
  - start is ignored outside IDLE.
- IDLE:
  - `player` and `problemID` hold their last values.
  - `score` = table[player].
  - start → SEL_PLAYER.
- SEL_PLAYER:
  - up/down step `player`, wrapping 3↔0.
  - ok → SEL_PROB.
- SEL_PROB:
  - up/down step `problemID`, wrapping MAX_PROB↔1.
  - ok → ADJUST; load working = table[player].
- ADJUST:
  - `score` = working.
  - up: working = min(working+STEP, SCORE_MAX).
  - down: working = max(working−STEP, 0). Compute in 9 bits so there is no wrap.
  - ok: table[player] ← working, `commit`=1, → IDLE.
  - A commit whose value equals the old score still pulses `commit`.
- Cancel in SEL_PLAYER, SEL_PROB or ADJUST:
  - → IDLE; working is discarded.
  - `score` reverts to table[player].
  - `player`/`problemID` keep their selected values.
- Reset at any point, including mid-ADJUST, behaves as the reset values below.
  - The working value is lost.
  - Undo history is cleared.

## Timing
- All outputs are registered. A button sampled at edge N is visible on the outputs after edge N.
- `commit` is high for exactly the cycle after the ok edge. `scores` shows the new value in that same cycle.
- Back-to-back pulses on consecutive cycles are each honoured; there is no rate limit.
- Reset values:
  - state IDLE, `stage`=0, `active`=0
  - `player`=0, `problemID`=1
  - all table entries = INIT_SCORE, so `score`=INIT_SCORE and `scores`={4{INIT_SCORE}}
  - `commit`=0, undo-valid=0

## Configuration
- `REJUDGE_UNDO_EN` defined:
  - Each commit saves {player, old score} and sets undo-valid.
  - `btn_undo` in IDLE with undo-valid restores that entry, pulses `commit`, clears undo-valid, and sets `player` to the restored player.
  - `btn_undo` in any other state, or with undo-valid=0, is ignored.
  - Only one level of undo is kept; a newer commit overwrites it.
- Not defined:
  - No undo storage is instantiated.
  - `btn_undo` is ignored.

## Test plan
- Reset, then start; up ×2; ok; up ×3; ok; up ×5; ok → `player`=2, `problemID`=4, `scores`[23:16]=5, one `commit` pulse, `stage`=0.
- Wrap: from player 0, press down → 3. With MAX_PROB=20, from problem 20 press up → 1.
- Saturation: table p1=98, ADJUST up ×3 → `score`=99. Then down ×100 → `score`=0, never 255.
- Cancel mid-ADJUST: p0=10, up ×4 (`score`=14), cancel → `score`=10, `scores` unchanged, no `commit`.
- Simultaneous: ok+up in SEL_PROB → advance only, `problemID` unchanged. up+down in ADJUST → no change. Reset asserted mid-ADJUST → all reset values.
- With `REJUDGE_UNDO_EN`: commit p3 7→12, then undo → p3=7, `commit` pulses. A second undo → ignored.

Source files
------------

// File: rtl/rejudge_ctrl.sv
// rejudge_ctrl: judge-side rejudge controller.
// Steps the judge through player -> problem -> score adjustment using
// single-cycle button pulses, then commits the adjusted score into a
// four-entry score table that is exported as a flat 32-bit bus.
// Optional feature: define REJUDGE_UNDO_EN to keep a one-level undo of the
// most recent table write.
module rejudge_ctrl #(
    parameter int MAX_PROB   = 20,
    parameter int STEP       = 1,
    parameter int SCORE_MAX  = 99,
    parameter int INIT_SCORE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    input  logic        btn_cancel,
    input  logic        btn_undo,
    output logic [1:0]  player,
    output logic [7:0]  problemID,
    output logic [7:0]  score,
    output logic        active,
    output logic [1:0]  stage,
    output logic        commit,
    output logic [31:0] scores
);

    // Handshake: every button is a one-cycle pulse with no ready/back-pressure.
    // A pulse sampled at a rising edge is acted on at that edge, and its
    // effect is visible on the outputs right after it; `commit` is a
    // one-cycle valid strobe that qualifies the new `scores` value.

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SEL_PLAYER = 2'd1,
        S_SEL_PROB   = 2'd2,
        S_ADJUST     = 2'd3
    } state_t;

    localparam logic [7:0] L_MAX_PROB  = 8'(MAX_PROB);
    localparam logic [8:0] L_STEP      = 9'(STEP);
    localparam logic [8:0] L_SCORE_MAX = 9'(SCORE_MAX);
    localparam logic [7:0] L_SAT_VAL   = 8'(SCORE_MAX);
    localparam logic [7:0] L_INIT      = 8'(INIT_SCORE);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_player, w_player_nxt;
    logic [7:0] r_prob, w_prob_nxt;
    logic [7:0] r_work, w_work_nxt;
    logic [7:0] r_table [4];
    logic       r_commit, w_commit_nxt;

    logic       w_wr_en;
    logic [1:0] w_wr_idx;
    logic [7:0] w_wr_val;
    logic       w_up;
    logic       w_down;
    logic [8:0] w_inc;
    logic [8:0] w_dec;
    logic       w_undo_fire;

`ifdef REJUDGE_UNDO_EN
    logic       r_undo_valid;
    logic [1:0] r_undo_player;
    logic [7:0] r_undo_score;
`else
    logic       w_unused_undo;
    assign w_unused_undo = btn_undo;
`endif

    // Up and down together cancel each other out.
    assign w_up   = btn_up & ~btn_down;
    assign w_down = btn_down & ~btn_up;
    // Nine-bit arithmetic so saturation is decided before any wrap.
    assign w_inc  = {1'b0, r_work} + L_STEP;
    assign w_dec  = {1'b0, r_work} - L_STEP;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath decode; priority cancel > ok > up > down.
    always_comb begin
        w_state_nxt  = r_state;
        w_player_nxt = r_player;
        w_prob_nxt   = r_prob;
        w_work_nxt   = r_work;
        w_commit_nxt = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_player;
        w_wr_val     = r_work;
        w_undo_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SEL_PLAYER;
`ifdef REJUDGE_UNDO_EN
                if (btn_undo && r_undo_valid) begin
                    w_undo_fire  = 1'b1;
                    w_wr_en      = 1'b1;
                    w_wr_idx     = r_undo_player;
                    w_wr_val     = r_undo_score;
                    w_player_nxt = r_undo_player;
                    w_commit_nxt = 1'b1;
                end
`endif
            end
            S_SEL_PLAYER: begin
                if (btn_cancel)  w_state_nxt  = S_IDLE;
                else if (btn_ok) w_state_nxt  = S_SEL_PROB;
                else if (w_up)   w_player_nxt = r_player + 2'd1;
                else if (w_down) w_player_nxt = r_player - 2'd1;
            end
            S_SEL_PROB: begin
                if (btn_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (btn_ok) begin
                    w_state_nxt = S_ADJUST;
                    w_work_nxt  = r_table[r_player];
                end else if (w_up) begin
                    w_prob_nxt = (r_prob >= L_MAX_PROB) ? 8'd1 : r_prob + 8'd1;
                end else if (w_down) begin
                    w_prob_nxt = (r_prob <= 8'd1) ? L_MAX_PROB : r_prob - 8'd1;
                end
            end
            S_ADJUST: begin
                if (btn_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (btn_ok) begin
                    w_state_nxt  = S_IDLE;
                    w_wr_en      = 1'b1;
                    w_commit_nxt = 1'b1;
                end else if (w_up) begin
                    w_work_nxt = (w_inc > L_SCORE_MAX) ? L_SAT_VAL : w_inc[7:0];
                end else if (w_down) begin
                    w_work_nxt = ({1'b0, r_work} < L_STEP) ? 8'd0 : w_dec[7:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Selection, working value, score table and commit strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_player <= 2'd0;
            r_prob   <= 8'd1;
            r_work   <= 8'd0;
            r_commit <= 1'b0;
            for (int i = 0; i < 4; i++) r_table[i] <= L_INIT;
        end else begin
            r_player <= w_player_nxt;
            r_prob   <= w_prob_nxt;
            r_work   <= w_work_nxt;
            r_commit <= w_commit_nxt;
            if (w_wr_en) r_table[w_wr_idx] <= w_wr_val;
        end
    end

`ifdef REJUDGE_UNDO_EN
    // One-level undo record: a normal commit saves the overwritten entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_undo_valid  <= 1'b0;
            r_undo_player <= 2'd0;
            r_undo_score  <= 8'd0;
        end else if (w_undo_fire) begin
            r_undo_valid <= 1'b0;
        end else if (w_commit_nxt) begin
            r_undo_valid  <= 1'b1;
            r_undo_player <= r_player;
            r_undo_score  <= r_table[r_player];
        end
    end
`endif

    assign player    = r_player;
    assign problemID = r_prob;
    assign score     = (r_state == S_ADJUST) ? r_work : r_table[r_player];
    assign active    = (r_state != S_IDLE);
    assign stage     = r_state;
    assign commit    = r_commit;
    assign scores    = {r_table[3], r_table[2], r_table[1], r_table[0]};

endmodule

// File: tb/tb_rejudge_ctrl.sv
// tb_rejudge_ctrl: directed bench for rejudge_ctrl with scoreboard checking.
// Driver tasks issue button pulses and push hand-computed expectations;
// a monitor process pops them at the matching cycle and compares.
module tb_rejudge_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start, btn_up, btn_down, btn_ok, btn_cancel, btn_undo;
    logic [1:0]  player;
    logic [7:0]  problemID;
    logic [7:0]  score;
    logic        active;
    logic [1:0]  stage;
    logic        commit;
    logic [31:0] scores;

    rejudge_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_ok     (btn_ok),
        .btn_cancel (btn_cancel),
        .btn_undo   (btn_undo),
        .player     (player),
        .problemID  (problemID),
        .score      (score),
        .active     (active),
        .stage      (stage),
        .commit     (commit),
        .scores     (scores)
    );

    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_STA  = 6'b100000;
    localparam logic [5:0] B_UP   = 6'b010000;
    localparam logic [5:0] B_DN   = 6'b001000;
    localparam logic [5:0] B_OK   = 6'b000100;
    localparam logic [5:0] B_CAN  = 6'b000010;
    localparam logic [5:0] B_UNDO = 6'b000001;

    typedef struct packed {
        logic [1:0]  stg;
        logic [1:0]  pl;
        logic [7:0]  pr;
        logic [7:0]  sc;
        logic        cm;
        logic [31:0] scs;
    } snap_t;
    localparam int EXP_W = $bits(snap_t);

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int unsigned      due_q[$];
    string            tag_q[$];
    logic [31:0]      commit_q[$];
    int unsigned      cyc_cnt = 0;
    int               checks  = 0;
    int               errors  = 0;
    snap_t            mon_e;
    string            mon_tag;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare snapshots due this cycle, and every commit strobe.
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] == cyc_cnt) begin
            void'(due_q.pop_front());
            mon_e   = snap_t'(exp_q.pop_front());
            mon_tag = tag_q.pop_front();
            chk({mon_tag, ".stage"},     32'(stage),     32'(mon_e.stg));
            chk({mon_tag, ".active"},    32'(active),    32'(mon_e.stg != 2'd0));
            chk({mon_tag, ".player"},    32'(player),    32'(mon_e.pl));
            chk({mon_tag, ".problemID"}, 32'(problemID), 32'(mon_e.pr));
            chk({mon_tag, ".score"},     32'(score),     32'(mon_e.sc));
            chk({mon_tag, ".commit"},    32'(commit),    32'(mon_e.cm));
            chk({mon_tag, ".scores"},    scores,         mon_e.scs);
        end
        if (commit === 1'b1) begin
            if (commit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got commit=1 expected commit=0 at cycle %0d", cyc_cnt);
            end else begin
                chk("commit_scores", scores, commit_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a rising edge.
    task automatic press(input logic [5:0] b);
        {start, btn_up, btn_down, btn_ok, btn_cancel, btn_undo} = b;
        @(posedge clk);
        #1;
        {start, btn_up, btn_down, btn_ok, btn_cancel, btn_undo} = B_NONE;
    endtask

    task automatic pressn(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic exp_out(input string tag, input logic [1:0] stg, input logic [1:0] pl,
                           input logic [7:0] pr, input logic [7:0] sc, input logic cm,
                           input logic [31:0] scs);
        snap_t            s;
        logic [EXP_W-1:0] v;
        s = '{stg: stg, pl: pl, pr: pr, sc: sc, cm: cm, scs: scs};
        v = s;
        exp_q.push_back(v);
        due_q.push_back(cyc_cnt);
        tag_q.push_back(tag);
    endtask

    task automatic exp_commit(input logic [31:0] scs);
        commit_q.push_back(scs);
    endtask

    // Watchdog: the stimulus is bounded, this only guards a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        {start, btn_up, btn_down, btn_ok, btn_cancel, btn_undo} = B_NONE;
        @(posedge clk);
        #1;
        do_reset();
        exp_out("reset", 2'd0, 2'd0, 8'd1, 8'd0, 1'b0, 32'h0);

        // Basic walk-through: player 2, problem 4, +5.
        press(B_STA);        exp_out("start",     2'd1, 2'd0, 8'd1, 8'd0, 1'b0, 32'h0);
        pressn(B_UP, 2);     exp_out("pl_up2",    2'd1, 2'd2, 8'd1, 8'd0, 1'b0, 32'h0);
        press(B_OK);         exp_out("to_prob",   2'd2, 2'd2, 8'd1, 8'd0, 1'b0, 32'h0);
        pressn(B_UP, 3);     exp_out("prob_up3",  2'd2, 2'd2, 8'd4, 8'd0, 1'b0, 32'h0);
        press(B_OK);         exp_out("to_adj",    2'd3, 2'd2, 8'd4, 8'd0, 1'b0, 32'h0);
        pressn(B_UP, 5);     exp_out("adj_up5",   2'd3, 2'd2, 8'd4, 8'd5, 1'b0, 32'h0);
        exp_commit(32'h0005_0000);
        press(B_OK);         exp_out("commit1",   2'd0, 2'd2, 8'd4, 8'd5, 1'b1, 32'h0005_0000);
        press(B_NONE);       exp_out("commit1_end", 2'd0, 2'd2, 8'd4, 8'd5, 1'b0, 32'h0005_0000);

        // Player and problem wrap in both directions.
        press(B_STA);
        press(B_UP);         exp_out("pl_to3",    2'd1, 2'd3, 8'd4, 8'd0, 1'b0, 32'h0005_0000);
        press(B_UP);         exp_out("pl_wrap_up", 2'd1, 2'd0, 8'd4, 8'd0, 1'b0, 32'h0005_0000);
        press(B_DN);         exp_out("pl_wrap_dn", 2'd1, 2'd3, 8'd4, 8'd0, 1'b0, 32'h0005_0000);
        press(B_UP);
        press(B_OK);
        pressn(B_UP, 16);    exp_out("prob_max",  2'd2, 2'd0, 8'd20, 8'd0, 1'b0, 32'h0005_0000);
        press(B_UP);         exp_out("prob_wrap_up", 2'd2, 2'd0, 8'd1, 8'd0, 1'b0, 32'h0005_0000);
        press(B_DN);         exp_out("prob_wrap_dn", 2'd2, 2'd0, 8'd20, 8'd0, 1'b0, 32'h0005_0000);
        press(B_CAN);        exp_out("cancel_prob", 2'd0, 2'd0, 8'd20, 8'd0, 1'b0, 32'h0005_0000);

        // Saturation at 99 and floor at 0 with p1 = 98.
        press(B_STA); press(B_UP); press(B_OK); press(B_OK);
        pressn(B_UP, 98);
        exp_commit(32'h0005_6200);
        press(B_OK);         exp_out("p1_98",     2'd0, 2'd1, 8'd20, 8'd98, 1'b1, 32'h0005_6200);
        press(B_STA); press(B_OK); press(B_OK);
        exp_out("sat_load", 2'd3, 2'd1, 8'd20, 8'd98, 1'b0, 32'h0005_6200);
        press(B_UP);         exp_out("sat_99",    2'd3, 2'd1, 8'd20, 8'd99, 1'b0, 32'h0005_6200);
        pressn(B_UP, 2);     exp_out("sat_hold",  2'd3, 2'd1, 8'd20, 8'd99, 1'b0, 32'h0005_6200);
        pressn(B_DN, 100);   exp_out("floor_0",   2'd3, 2'd1, 8'd20, 8'd0, 1'b0, 32'h0005_6200);
        press(B_DN);         exp_out("floor_hold", 2'd3, 2'd1, 8'd20, 8'd0, 1'b0, 32'h0005_6200);
        press(B_CAN);        exp_out("sat_cancel", 2'd0, 2'd1, 8'd20, 8'd98, 1'b0, 32'h0005_6200);

        // Cancel mid-ADJUST with p0 = 10.
        press(B_STA); press(B_DN); press(B_OK); press(B_OK);
        pressn(B_UP, 10);
        exp_commit(32'h0005_620A);
        press(B_OK);         exp_out("p0_10",     2'd0, 2'd0, 8'd20, 8'd10, 1'b1, 32'h0005_620A);
        press(B_STA); press(B_OK); press(B_OK);
        pressn(B_UP, 4);     exp_out("adj_14",    2'd3, 2'd0, 8'd20, 8'd14, 1'b0, 32'h0005_620A);
        press(B_CAN);        exp_out("cancel_adj", 2'd0, 2'd0, 8'd20, 8'd10, 1'b0, 32'h0005_620A);

        // Simultaneous buttons and start outside IDLE.
        press(B_STA);
        press(B_STA);        exp_out("start_ign", 2'd1, 2'd0, 8'd20, 8'd10, 1'b0, 32'h0005_620A);
        press(B_OK);
        press(B_OK | B_UP);  exp_out("ok_up",     2'd3, 2'd0, 8'd20, 8'd10, 1'b0, 32'h0005_620A);
        press(B_UP | B_DN);  exp_out("up_dn",     2'd3, 2'd0, 8'd20, 8'd10, 1'b0, 32'h0005_620A);
        press(B_UP);         exp_out("adj_11",    2'd3, 2'd0, 8'd20, 8'd11, 1'b0, 32'h0005_620A);
        press(B_CAN | B_OK); exp_out("cancel_ok", 2'd0, 2'd0, 8'd20, 8'd10, 1'b0, 32'h0005_620A);

        // Reset in the middle of ADJUST.
        press(B_STA); press(B_OK); press(B_OK);
        pressn(B_UP, 3);     exp_out("pre_rst",   2'd3, 2'd0, 8'd20, 8'd13, 1'b0, 32'h0005_620A);
        do_reset();          exp_out("rst_adj",   2'd0, 2'd0, 8'd1, 8'd0, 1'b0, 32'h0);

        // Commit p3 = 7, then exercise undo.
        press(B_STA); press(B_DN); press(B_OK); press(B_OK);
        pressn(B_UP, 7);
        exp_commit(32'h0700_0000);
        press(B_OK);         exp_out("p3_7",      2'd0, 2'd3, 8'd1, 8'd7, 1'b1, 32'h0700_0000);
`ifdef REJUDGE_UNDO_EN
        press(B_STA); press(B_OK); press(B_OK);
        pressn(B_UP, 5);
        exp_commit(32'h0C00_0000);
        press(B_OK);         exp_out("p3_12",     2'd0, 2'd3, 8'd1, 8'd12, 1'b1, 32'h0C00_0000);
        press(B_STA); press(B_UP);
        press(B_CAN);        exp_out("pl0_idle",  2'd0, 2'd0, 8'd1, 8'd0, 1'b0, 32'h0C00_0000);
        exp_commit(32'h0700_0000);
        press(B_UNDO);       exp_out("undo",      2'd0, 2'd3, 8'd1, 8'd7, 1'b1, 32'h0700_0000);
        press(B_UNDO);       exp_out("undo2_ign", 2'd0, 2'd3, 8'd1, 8'd7, 1'b0, 32'h0700_0000);
`else
        press(B_UNDO);       exp_out("undo_ign",  2'd0, 2'd3, 8'd1, 8'd7, 1'b0, 32'h0700_0000);
`endif
        pressn(B_NONE, 3);

        // ---------------- final report ----------------
        @(negedge clk);
        @(negedge clk);
        chk("exp_q_drained",    32'(exp_q.size()),    32'd0);
        chk("commit_q_drained", 32'(commit_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
